// File: rtl/calc_sequencer.sv
// Calculator key sequencer: builds signed operands from key events, issues one ALU op on '=',
// and presents the result/error. Optional ALU watchdog is enabled by defining CALC_TIMEOUT_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_ENTRY_A | building operand A, display shows A
// ST_ENTRY_B | operator latched, building operand B (display A until first B digit)
// ST_EXEC    | ALU operation in flight, keys held off
// ST_RESULT  | ALU result R shown; operator chains R into A
// ST_ERROR   | overflow/negation error shown, only digit or clear leaves
module calc_sequencer #(
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              key_rdy,
    output logic              key_rd,
    input  logic [3:0]        keypad_input,
    input  logic [2:0]        operator_input,
    input  logic              equal_input,
    output logic              alu_start,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ovf,
    output logic [DATA_W-1:0] disp_value,
    output logic              disp_err,
    output logic              busy
);

    typedef enum logic [2:0] {
        ST_ENTRY_A,
        ST_ENTRY_B,
        ST_EXEC,
        ST_RESULT,
        ST_ERROR
    } state_t;

    localparam int EXT_W = DATA_W + 4;
    localparam logic signed [EXT_W-1:0] MAXV     = {5'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] TEN      = EXT_W'(10);
    localparam logic        [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [2:0] OP_NEG = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b100;

`ifdef CALC_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    // Out-of-range digits are silently dropped so the operand never exceeds +/-MAXV.
    function automatic logic [DATA_W-1:0] digit_entry(input logic [DATA_W-1:0] x,
                                                      input logic [3:0]        d);
        logic signed [EXT_W-1:0] x_ext;
        logic signed [EXT_W-1:0] d_ext;
        logic signed [EXT_W-1:0] nxt;
        x_ext = {{4{x[DATA_W-1]}}, x};
        d_ext = {{(EXT_W-4){1'b0}}, d};
        nxt   = x[DATA_W-1] ? (x_ext * TEN - d_ext) : (x_ext * TEN + d_ext);
        if (nxt > MAXV || nxt < -MAXV) return x;
        return nxt[DATA_W-1:0];
    endfunction

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic [2:0]        op_q, op_d;
    logic              b_has_q, b_has_d;
    logic              key_taken_q, key_taken_d;
    logic              key_rd_q, key_rd_d;
    logic              alu_start_q, alu_start_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [DATA_W-1:0] disp_value_q, disp_value_d;
    logic              disp_err_q, disp_err_d;
    logic              busy_q, busy_d;

    logic              accept, exec_done;
    logic              is_eq, is_neg, is_arith, is_dig, is_clr;
    logic [DATA_W-1:0] digit_val;

    always_comb begin
        accept    = key_rdy && !key_taken_q && (state_q != ST_EXEC);
        // Completion in the alu_start cycle is ignored; earliest is one cycle later.
        exec_done = (state_q == ST_EXEC) && !alu_start_q && alu_done;
        is_eq     = equal_input;
        is_neg    = !equal_input && (operator_input == OP_NEG);
        is_arith  = !equal_input && (operator_input >= OP_ADD) && (operator_input <= OP_MUL);
        is_dig    = !equal_input && (operator_input == 3'b000) && (keypad_input <= 4'd9);
        is_clr    = !equal_input && (operator_input == 3'b000) && (keypad_input == 4'hF);
        digit_val = {{(DATA_W-4){1'b0}}, keypad_input};

        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        r_d         = r_q;
        op_d        = op_q;
        b_has_d     = b_has_q;
        key_rd_d    = 1'b0;
        alu_start_d = 1'b0;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
`ifdef CALC_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
`endif

        if (accept)       key_taken_d = 1'b1;
        else if (!key_rdy) key_taken_d = 1'b0;
        else              key_taken_d = key_taken_q;

        if (accept) begin
            key_rd_d = 1'b1;
            if (is_clr) begin
                a_d     = '0;
                b_d     = '0;
                op_d    = 3'b000;
                b_has_d = 1'b0;
                state_d = ST_ENTRY_A;
            end else begin
                case (state_q)
                    ST_ENTRY_A: begin
                        if (is_dig)      a_d = digit_entry(a_q, keypad_input);
                        else if (is_neg) a_d = -a_q;
                        else if (is_arith) begin
                            op_d    = operator_input;
                            b_d     = '0;
                            b_has_d = 1'b0;
                            state_d = ST_ENTRY_B;
                        end
                    end
                    ST_ENTRY_B: begin
                        if (is_eq) begin
                            if (b_has_q) begin
                                alu_start_d = 1'b1;
                                alu_a_d     = a_q;
                                alu_b_d     = b_q;
                                alu_op_d    = op_q;
                                state_d     = ST_EXEC;
`ifdef CALC_TIMEOUT_EN
                                to_cnt_d    = '0;
`endif
                            end
                        end else if (is_dig) begin
                            b_d     = digit_entry(b_q, keypad_input);
                            b_has_d = 1'b1;
                        end else if (is_neg) begin
                            b_d = -b_q;
                        end else if (is_arith) begin
                            op_d = operator_input;
                        end
                    end
                    ST_RESULT: begin
                        if (is_arith) begin
                            a_d     = r_q;
                            op_d    = operator_input;
                            b_d     = '0;
                            b_has_d = 1'b0;
                            state_d = ST_ENTRY_B;
                        end else if (is_dig) begin
                            a_d     = digit_val;
                            state_d = ST_ENTRY_A;
                        end else if (is_neg) begin
                            if (r_q == MOST_NEG) state_d = ST_ERROR;
                            else begin
                                a_d     = -r_q;
                                state_d = ST_ENTRY_A;
                            end
                        end
                    end
                    ST_ERROR: begin
                        if (is_dig) begin
                            a_d     = digit_val;
                            state_d = ST_ENTRY_A;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (state_q == ST_EXEC) begin
            if (exec_done) begin
                if (alu_ovf) state_d = ST_ERROR;
                else begin
                    r_d     = alu_result;
                    state_d = ST_RESULT;
                end
            end
`ifdef CALC_TIMEOUT_EN
            else if (to_cnt_q == TO_LIMIT) state_d = ST_ERROR;
            else to_cnt_d = to_cnt_q + TO_W'(1);
`endif
        end

        // Display outputs are registered from next-state values so they track the state.
        busy_d     = (state_d == ST_EXEC);
        disp_err_d = (state_d == ST_ERROR);
        case (state_d)
            ST_ENTRY_A: disp_value_d = a_d;
            ST_ENTRY_B: disp_value_d = b_has_d ? b_d : a_d;
            ST_RESULT:  disp_value_d = r_d;
            ST_ERROR:   disp_value_d = '0;
            default:    disp_value_d = disp_value_q;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q      <= ST_ENTRY_A;
            a_q          <= '0;
            b_q          <= '0;
            r_q          <= '0;
            op_q         <= 3'b000;
            b_has_q      <= 1'b0;
            key_taken_q  <= 1'b0;
            key_rd_q     <= 1'b0;
            alu_start_q  <= 1'b0;
            alu_op_q     <= 3'b000;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            disp_value_q <= '0;
            disp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
`ifdef CALC_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            r_q          <= r_d;
            op_q         <= op_d;
            b_has_q      <= b_has_d;
            key_taken_q  <= key_taken_d;
            key_rd_q     <= key_rd_d;
            alu_start_q  <= alu_start_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            disp_value_q <= disp_value_d;
            disp_err_q   <= disp_err_d;
            busy_q       <= busy_d;
`ifdef CALC_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    assign key_rd     = key_rd_q;
    assign alu_start  = alu_start_q;
    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign disp_value = disp_value_q;
    assign disp_err   = disp_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: key-sequence vector table plus hand-written
// multi-cycle sequences (chaining, key held through EXEC, reset in EXEC, errors).
module tb_calc_sequencer;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         nRST = 1'b0;
    logic         key_rdy = 1'b0;
    logic         key_rd;
    logic [3:0]   keypad_input = 4'hF;
    logic [2:0]   operator_input = 3'b000;
    logic         equal_input = 1'b0;
    logic         alu_start;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_a, alu_b;
    logic         alu_done = 1'b0;
    logic [W-1:0] alu_result = '0;
    logic         alu_ovf = 1'b0;
    logic [W-1:0] disp_value;
    logic         disp_err;
    logic         busy;

    calc_sequencer #(.DATA_W(W), .TIMEOUT_CYC(255)) dut (
        .clk(clk), .nRST(nRST), .key_rdy(key_rdy), .key_rd(key_rd),
        .keypad_input(keypad_input), .operator_input(operator_input),
        .equal_input(equal_input), .alu_start(alu_start), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done), .alu_result(alu_result),
        .alu_ovf(alu_ovf), .disp_value(disp_value), .disp_err(disp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int ack_cnt = 0;
    int start_cnt = 0;
    time last_ack_t = 0;
    time done_t = 0;
    logic [W-1:0] cap_a = '0, cap_b = '0;
    logic [2:0]   cap_op = '0;

    always @(negedge clk) begin
        if (key_rd) begin
            ack_cnt++;
            last_ack_t = $time;
        end
        if (alu_start) begin
            start_cnt++;
            cap_a  = alu_a;
            cap_b  = alu_b;
            cap_op = alu_op;
        end
    end

    typedef struct {
        string keys;
        int    res;
        bit    ovf;
        bit    exp_start;
        int    exp_a;
        int    exp_b;
        int    exp_op;
        int    exp_disp;
        bit    exp_err;
    } vec_t;

    function automatic vec_t mk(string k, int res, bit ovf, bit st, int a, int b, int op,
                                int disp, bit err);
        vec_t v;
        v.keys = k; v.res = res; v.ovf = ovf; v.exp_start = st;
        v.exp_a = a; v.exp_b = b; v.exp_op = op; v.exp_disp = disp; v.exp_err = err;
        return v;
    endfunction

    function automatic int sv(input logic [W-1:0] x);
        return int'($signed(x));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Key map: 0-9 digits, A add, B sub, C mul, D neg, * equals, # clear (all idle).
    task automatic press(input byte c);
        bit got;
        keypad_input   = 4'hF;
        operator_input = 3'b000;
        equal_input    = 1'b0;
        if (c >= "0" && c <= "9") keypad_input = 4'(c - "0");
        else if (c == "A") operator_input = 3'b010;
        else if (c == "B") operator_input = 3'b011;
        else if (c == "C") operator_input = 3'b100;
        else if (c == "D") operator_input = 3'b001;
        else if (c == "*") equal_input = 1'b1;
        key_rdy = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (key_rd) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL key_ack_timeout: key %s got no key_rd expected one", c);
        end
        key_rdy        = 1'b0;
        keypad_input   = 4'hF;
        operator_input = 3'b000;
        equal_input    = 1'b0;
        tick();
    endtask

    task automatic press_str(input string s);
        for (int k = 0; k < s.len(); k++) press(s[k]);
    endtask

    task automatic respond(input int res, input bit ovf, input int dly);
        repeat (dly) tick();
        alu_done   = 1'b1;
        alu_result = res[W-1:0];
        alu_ovf    = ovf;
        done_t     = $time;
        tick();
        alu_done = 1'b0;
        alu_ovf  = 1'b0;
        tick();
    endtask

    vec_t vecs[12];
    int s0, a0;

    initial begin
        vecs[0]  = mk("12A34*",   46, 0, 1, 12, 34, 2, 46, 0);
        vecs[1]  = mk("5B7D*",    12, 0, 1, 5, -7, 3, 12, 0);
        vecs[2]  = mk("200C200*", 0,  1, 1, 200, 200, 4, 0, 1);
        vecs[3]  = mk("32768",    0,  0, 0, 0, 0, 0, 3276, 0);
        vecs[4]  = mk("327687",   0,  0, 0, 0, 0, 0, 32767, 0);
        vecs[5]  = mk("3276871",  0,  0, 0, 0, 0, 0, 32767, 0);
        vecs[6]  = mk("3276D8",   0,  0, 0, 0, 0, 0, -3276, 0);
        vecs[7]  = mk("3276D78",  0,  0, 0, 0, 0, 0, -32767, 0);
        vecs[8]  = mk("12A*",     0,  0, 0, 0, 0, 0, 12, 0);
        vecs[9]  = mk("5A7D",     0,  0, 0, 0, 0, 0, -7, 0);
        vecs[10] = mk("5AB9*",    -4, 0, 1, 5, 9, 3, -4, 0);
        vecs[11] = mk("*0D5",     0,  0, 0, 0, 0, 0, 5, 0);

        repeat (3) tick();
        chk("rst_key_rd", int'(key_rd), 0);
        chk("rst_alu_start", int'(alu_start), 0);
        chk("rst_outputs", int'({alu_op, alu_a, alu_b, disp_value} != 0), 0);
        chk("rst_err_busy", int'({disp_err, busy}), 0);
        nRST = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            press("#");
            s0 = start_cnt;
            a0 = ack_cnt;
            press_str(vecs[i].keys);
            if (vecs[i].exp_start) respond(vecs[i].res, vecs[i].ovf, 2);
            chk($sformatf("v%0d_starts", i), start_cnt - s0, int'(vecs[i].exp_start));
            if (vecs[i].exp_start) begin
                chk($sformatf("v%0d_alu_a", i), sv(cap_a), vecs[i].exp_a);
                chk($sformatf("v%0d_alu_b", i), sv(cap_b), vecs[i].exp_b);
                chk($sformatf("v%0d_alu_op", i), int'(cap_op), vecs[i].exp_op);
            end
            chk($sformatf("v%0d_acks", i), ack_cnt - a0, vecs[i].keys.len());
            chk($sformatf("v%0d_disp", i), sv(disp_value), vecs[i].exp_disp);
            chk($sformatf("v%0d_err", i), int'(disp_err), int'(vecs[i].exp_err));
        end

        // error recovery: non-digit keys ignored but acked, digit restarts entry
        press("#");
        press_str("200C200*");
        respond(0, 1, 3);
        chk("err_set", int'(disp_err), 1);
        a0 = ack_cnt;
        press("A");
        chk("err_op_acked", ack_cnt - a0, 1);
        chk("err_op_ignored", int'(disp_err), 1);
        press("4");
        chk("err_digit_clr", int'(disp_err), 0);
        chk("err_digit_val", sv(disp_value), 4);
        press("5");
        chk("err_then_entry_a", sv(disp_value), 45);

        // chaining, then a key held through EXEC
        press("#");
        press_str("12A34*");
        respond(46, 0, 2);
        chk("chain_r1", sv(disp_value), 46);
        s0 = start_cnt;
        press_str("A4*");
        chk("chain_start", start_cnt - s0, 1);
        chk("chain_alu_a", sv(cap_a), 46);
        chk("chain_alu_b", sv(cap_b), 4);
        chk("chain_alu_op", int'(cap_op), 2);
        chk("chain_busy", int'(busy), 1);
        a0 = ack_cnt;
        fork
            press("7");
            respond(50, 0, 4);
        join
        chk("held_one_ack", ack_cnt - a0, 1);
        chk("held_ack_after_done", int'(last_ack_t > done_t), 1);
        chk("held_digit_disp", sv(disp_value), 7);
        chk("held_busy_low", int'(busy), 0);

        // negating a result, including the most-negative value
        press("#");
        press_str("1A1*");
        respond(46, 0, 1);
        press("D");
        chk("res_neg_disp", sv(disp_value), -46);
        chk("res_neg_err", int'(disp_err), 0);
        press("#");
        press_str("1A1*");
        respond(-32768, 0, 1);
        chk("res_mostneg_disp", sv(disp_value), -32768);
        press("D");
        chk("res_mostneg_err", int'(disp_err), 1);
        chk("res_mostneg_zero", sv(disp_value), 0);

        // reset while EXEC, followed by a stale alu_done
        press("#");
        press_str("1A1*");
        chk("rexec_busy", int'(busy), 1);
        s0 = start_cnt;
        nRST = 1'b0;
        #2;
        chk("rexec_alu_a", sv(alu_a), 0);
        chk("rexec_alu_b", sv(alu_b), 0);
        chk("rexec_alu_op", int'(alu_op), 0);
        chk("rexec_busy_rst", int'(busy), 0);
        chk("rexec_misc", int'({key_rd, alu_start, disp_err}), 0);
        tick();
        tick();
        nRST = 1'b1;
        tick();
        alu_done   = 1'b1;
        alu_result = 16'd99;
        tick();
        alu_done = 1'b0;
        tick();
        tick();
        chk("rexec_late_done_disp", sv(disp_value), 0);
        chk("rexec_no_start", start_cnt - s0, 0);
        press("5");
        chk("rexec_entry_a", sv(disp_value), 5);

`ifdef CALC_TIMEOUT_EN
        press("#");
        press_str("1A1*");
        for (int i = 0; i < 400 && !disp_err; i++) tick();
        chk("timeout_err", int'(disp_err), 1);
        chk("timeout_busy", int'(busy), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
